// File: rtl/mem_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch (IF) and data memory (DM).
// Each access is a fixed IDLE -> ACCESS x (WAIT_CYCLES+1) -> DONE transaction.
//   state     | meaning
//   ST_IDLE   | sample requests, DM wins, latch address/data of the winner
//   ST_ACCESS | drive SRAM strobes, count down wait states, capture read data
//   ST_DONE   | one-cycle done pulse to the owner, strobes low
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned RAM_AW      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              ram_we,
  output logic              ram_oe
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                owner_dm_q, owner_dm_d;
  logic                we_q, we_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         dm_rdata_q, dm_rdata_d;

  // Word addressing drops the byte offset; bits above the SRAM range are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:RAM_AW+2], if_addr[1:0],
                              dm_addr[31:RAM_AW+2], dm_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_dm_q <= owner_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_dm_d = owner_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (dm_req) begin
          owner_dm_d = 1'b1;
          addr_d     = dm_addr[RAM_AW+1:2];
          we_d       = dm_we;
          wdata_d    = dm_wdata;
          cnt_d      = WAIT_INIT;
          state_d    = ST_ACCESS;
        end else if (if_req) begin
          owner_dm_d = 1'b0;
          addr_d     = if_addr[RAM_AW+1:2];
          we_d       = 1'b0;
          cnt_d      = WAIT_INIT;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (owner_dm_q) dm_rdata_d = ram_rdata;
            else            if_data_d  = ram_rdata;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = (state_q == ST_ACCESS) &&  we_q;
  assign ram_oe    = (state_q == ST_ACCESS) && !we_q;
  assign if_done   = (state_q == ST_DONE) && !owner_dm_q;
  assign dm_done   = (state_q == ST_DONE) &&  owner_dm_q;
  assign if_data   = if_data_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = rst && if_req && !if_done;
  assign dm_stall  = rst && dm_req && !dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with WAIT_CYCLES=1 on a small SRAM model,
// one with WAIT_CYCLES=0 on an address-pattern SRAM for the back-to-back fetch case.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_data1, dm_rdata1, ram_wdata1, ram_rdata1;
  logic        if_done1, if_stall1, dm_done1, dm_stall1, ram_we1, ram_oe1;
  logic [19:0] ram_addr1;

  logic        if_req0;
  logic [31:0] if_addr0;
  logic [31:0] if_data0, dm_rdata0, ram_wdata0, ram_rdata0;
  logic        if_done0, if_stall0, dm_done0, dm_stall0, ram_we0, ram_oe0;
  logic [19:0] ram_addr0;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.WAIT_CYCLES(1), .RAM_AW(20)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data1), .if_done(if_done1), .if_stall(if_stall1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata1), .dm_done(dm_done1), .dm_stall(dm_stall1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1),
    .ram_we(ram_we1), .ram_oe(ram_oe1)
  );

  mem_port_arbiter #(.WAIT_CYCLES(0), .RAM_AW(20)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req0), .if_addr(if_addr0), .if_data(if_data0), .if_done(if_done0), .if_stall(if_stall0),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_rdata(dm_rdata0), .dm_done(dm_done0), .dm_stall(dm_stall0),
    .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0),
    .ram_we(ram_we0), .ram_oe(ram_oe0)
  );

  // SRAM model: preset contents plus a write overlay.
  logic [31:0] wr_mem   [0:255] = '{default: 32'h0};
  logic        wr_valid [0:255] = '{default: 1'b0};

  function automatic logic [31:0] init_word(input logic [7:0] a);
    case (a)
      8'd4:    return 32'hDEAD_BEEF;
      8'd5:    return 32'h55AA_55AA;
      default: return 32'h1000_0000 | 32'(a);
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_we1) begin
      wr_mem[ram_addr1[7:0]]   <= ram_wdata1;
      wr_valid[ram_addr1[7:0]] <= 1'b1;
    end
  end

  assign ram_rdata1 = wr_valid[ram_addr1[7:0]] ? wr_mem[ram_addr1[7:0]] : init_word(ram_addr1[7:0]);
  assign ram_rdata0 = 32'hC0DE_0000 | 32'(ram_addr0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Invariants: never both done, never we and oe together.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("inv_done1", {30'd0, if_done1, dm_done1} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
      chk("inv_weoe1", 32'(ram_we1 & ram_oe1), 32'd0);
      chk("inv_weoe0", 32'(ram_we0 & ram_oe0), 32'd0);
    end
  end

  initial begin
    rst = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    if_req0 = 1'b0; if_addr0 = '0;

    // Reset values, stall gated while in reset
    repeat (2) @(negedge clk);
    if_req = 1'b1; dm_req = 1'b1;
    #1;
    chk("rst_if_stall", 32'(if_stall1), 32'd0);
    chk("rst_dm_stall", 32'(dm_stall1), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr1), 32'd0);
    chk("rst_ram_oe", 32'(ram_oe1), 32'd0);
    chk("rst_ram_we", 32'(ram_we1), 32'd0);
    chk("rst_if_data", if_data1, 32'd0);
    chk("rst_dm_rdata", dm_rdata1, 32'd0);
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    cyc();

    // IF read, WAIT_CYCLES=1
    @(negedge clk); if_req = 1'b1; if_addr = 32'h10; #1;
    chk("t1_c1_stall", 32'(if_stall1), 32'd1);
    chk("t1_c1_oe", 32'(ram_oe1), 32'd0);
    cyc();
    chk("t1_c2_addr", 32'(ram_addr1), 32'd4);
    chk("t1_c2_oe", 32'(ram_oe1), 32'd1);
    chk("t1_c2_we", 32'(ram_we1), 32'd0);
    chk("t1_c2_done", 32'(if_done1), 32'd0);
    chk("t1_c2_stall", 32'(if_stall1), 32'd1);
    cyc();
    chk("t1_c3_oe", 32'(ram_oe1), 32'd1);
    chk("t1_c3_done", 32'(if_done1), 32'd0);
    chk("t1_c3_stall", 32'(if_stall1), 32'd1);
    cyc();
    chk("t1_c4_done", 32'(if_done1), 32'd1);
    chk("t1_c4_data", if_data1, 32'hDEAD_BEEF);
    chk("t1_c4_stall", 32'(if_stall1), 32'd0);
    chk("t1_c4_oe", 32'(ram_oe1), 32'd0);
    if_req = 1'b0;
    cyc();
    chk("t1_c5_done", 32'(if_done1), 32'd0);
    chk("t1_c5_data", if_data1, 32'hDEAD_BEEF);
    chk("t1_c5_addr", 32'(ram_addr1), 32'd4);

    // Simultaneous requests: DM write first, then IF reads the written word
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h1234_5678; #1;
    chk("t2_c1_if_stall", 32'(if_stall1), 32'd1);
    chk("t2_c1_dm_stall", 32'(dm_stall1), 32'd1);
    cyc();
    chk("t2_c2_addr", 32'(ram_addr1), 32'd8);
    chk("t2_c2_we", 32'(ram_we1), 32'd1);
    chk("t2_c2_oe", 32'(ram_oe1), 32'd0);
    chk("t2_c2_wdata", ram_wdata1, 32'h1234_5678);
    dm_addr = 32'h40; dm_wdata = 32'hFFFF_FFFF;
    cyc();
    chk("t2_c3_we", 32'(ram_we1), 32'd1);
    chk("t2_c3_addr", 32'(ram_addr1), 32'd8);
    chk("t2_c3_wdata", ram_wdata1, 32'h1234_5678);
    cyc();
    chk("t2_c4_dm_done", 32'(dm_done1), 32'd1);
    chk("t2_c4_if_done", 32'(if_done1), 32'd0);
    chk("t2_c4_we", 32'(ram_we1), 32'd0);
    chk("t2_c4_dm_rdata", dm_rdata1, 32'd0);
    dm_req = 1'b0; #1;
    chk("t2_c4_dm_stall", 32'(dm_stall1), 32'd0);
    cyc();
    chk("t2_c5_if_stall", 32'(if_stall1), 32'd1);
    chk("t2_c5_we", 32'(ram_we1), 32'd0);
    chk("t2_c5_oe", 32'(ram_oe1), 32'd0);
    chk("t2_c5_dm_done", 32'(dm_done1), 32'd0);
    cyc();
    chk("t2_c6_addr", 32'(ram_addr1), 32'd8);
    chk("t2_c6_oe", 32'(ram_oe1), 32'd1);
    cyc();
    chk("t2_c7_done", 32'(if_done1), 32'd0);
    cyc();
    chk("t2_c8_done", 32'(if_done1), 32'd1);
    chk("t2_c8_data", if_data1, 32'h1234_5678);
    if_req = 1'b0;
    cyc();

    // DM read with request withdrawn during ACCESS
    @(negedge clk); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h14; #1;
    chk("t3_c1_stall", 32'(dm_stall1), 32'd1);
    cyc();
    chk("t3_c2_addr", 32'(ram_addr1), 32'd5);
    chk("t3_c2_oe", 32'(ram_oe1), 32'd1);
    dm_req = 1'b0; #1;
    chk("t3_c2_stall", 32'(dm_stall1), 32'd0);
    cyc();
    chk("t3_c3_done", 32'(dm_done1), 32'd0);
    cyc();
    chk("t3_c4_done", 32'(dm_done1), 32'd1);
    chk("t3_c4_rdata", dm_rdata1, 32'h55AA_55AA);
    chk("t3_c4_if_data", if_data1, 32'h1234_5678);
    cyc();
    chk("t3_c5_done", 32'(dm_done1), 32'd0);
    chk("t3_c5_rdata", dm_rdata1, 32'h55AA_55AA);

    // Reset in the middle of a write
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h30; dm_wdata = 32'hCAFE_F00D;
    if_req = 1'b1; if_addr = 32'h10;
    cyc();
    chk("t4_we_before", 32'(ram_we1), 32'd1);
    #1 rst = 1'b0; #1;
    chk("t4_we", 32'(ram_we1), 32'd0);
    chk("t4_oe", 32'(ram_oe1), 32'd0);
    chk("t4_addr", 32'(ram_addr1), 32'd0);
    chk("t4_wdata", ram_wdata1, 32'd0);
    chk("t4_if_data", if_data1, 32'd0);
    chk("t4_dm_rdata", dm_rdata1, 32'd0);
    chk("t4_dm_done", 32'(dm_done1), 32'd0);
    chk("t4_if_done", 32'(if_done1), 32'd0);
    chk("t4_dm_stall", 32'(dm_stall1), 32'd0);
    chk("t4_if_stall", 32'(if_stall1), 32'd0);
    dm_req = 1'b0; if_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_no_write", 32'(wr_valid[12]), 32'd0);
    chk("t4_done_held", 32'(dm_done1 | if_done1), 32'd0);
    rst = 1'b1;
    cyc();

    // Post-reset IF service with misaligned address
    @(negedge clk); if_req = 1'b1; if_addr = 32'h13; #1;
    chk("t5_c1_stall", 32'(if_stall1), 32'd1);
    cyc();
    chk("t5_c2_addr", 32'(ram_addr1), 32'd4);
    chk("t5_c2_oe", 32'(ram_oe1), 32'd1);
    cyc();
    cyc();
    chk("t5_c4_done", 32'(if_done1), 32'd1);
    chk("t5_c4_data", if_data1, 32'hDEAD_BEEF);
    if_req = 1'b0;
    cyc();

    // Back-to-back IF, WAIT_CYCLES=0
    @(negedge clk); if_req0 = 1'b1; if_addr0 = 32'h0; #1;
    chk("t6_c1_stall", 32'(if_stall0), 32'd1);
    cyc();
    chk("t6_c2_addr", 32'(ram_addr0), 32'd0);
    chk("t6_c2_oe", 32'(ram_oe0), 32'd1);
    chk("t6_c2_done", 32'(if_done0), 32'd0);
    cyc();
    chk("t6_c3_done", 32'(if_done0), 32'd1);
    chk("t6_c3_data", if_data0, 32'hC0DE_0000);
    if_addr0 = 32'h4;
    cyc();
    chk("t6_c4_done", 32'(if_done0), 32'd0);
    chk("t6_c4_stall", 32'(if_stall0), 32'd1);
    chk("t6_c4_oe", 32'(ram_oe0), 32'd0);
    cyc();
    chk("t6_c5_addr", 32'(ram_addr0), 32'd1);
    chk("t6_c5_oe", 32'(ram_oe0), 32'd1);
    cyc();
    chk("t6_c6_done", 32'(if_done0), 32'd1);
    chk("t6_c6_data", if_data0, 32'hC0DE_0001);
    if_req0 = 1'b0;
    cyc();
    chk("t6_c7_done", 32'(if_done0), 32'd0);
    chk("t6_dm_rdata0", dm_rdata0, 32'd0);
    chk("t6_dm_stall0", 32'(dm_stall0), 32'd0);
    chk("t6_dm_done0", 32'(dm_done0), 32'd0);
    chk("t6_ram_wdata0", ram_wdata0, 32'd0);
    chk("t6_ram_we0", 32'(ram_we0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and access sequencer for the armcpu core. It shares one external synchronous-handshake SRAM port between the instruction-fetch stage (IF) and the data-memory stage (DM). It runs every access as a fixed multi-cycle transaction with programmable wait states and returns registered read data. It drives per-requester stall signals, so the pipeline freezes while its access is pending or in flight.

## Interface
- `WAIT_CYCLES`, default 1: extra SRAM cycles per access; legal range 0..15.
- `RAM_AW`, default 20: SRAM word-address width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset; **asynchronous, active-low**.
- `if_req`  in  1  IF requests an instruction read.
- `if_addr`  in  32  IF byte address; bits [1:0] are ignored.
- `if_data`  out  32  registered read data; valid while `if_done`=1.
- `if_done`  out  1  one-cycle pulse: IF access complete.
- `if_stall`  out  1  equals `if_req & ~if_done`.
- `dm_req`  in  1  DM requests an access.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  32  DM byte address; bits [1:0] are ignored.
- `dm_wdata`  in  32  write data.
- `dm_rdata`  out  32  registered read data; valid while `dm_done`=1.
- `dm_done`  out  1  one-cycle pulse: DM access complete.
- `dm_stall`  out  1  equals `dm_req & ~dm_done`.
- `ram_addr`  out  RAM_AW  SRAM word address.
- `ram_wdata`  out  32  SRAM write data.
- `ram_rdata`  in  32  SRAM read data; sampled on the final ACCESS edge.
- `ram_we`  out  1  SRAM write strobe.
- `ram_oe`  out  1  SRAM output enable.

## Operation
The arbiter is a three-state FSM: IDLE, ACCESS, DONE.

**IDLE**
- Samples the requests.
- `dm_req`=1 takes priority: latch owner=DM, `dm_addr[RAM_AW+1:2]`, `dm_we`, `dm_wdata`.
- Otherwise, `if_req`=1: latch owner=IF, `if_addr[RAM_AW+1:2]`, we=0.
- Either grant loads `cnt`=WAIT_CYCLES and moves to ACCESS.
- No request: remain in IDLE.

**ACCESS**
- `ram_addr` and `ram_wdata` come from the latched values.
- Write: `ram_we`=1, `ram_oe`=0. Read: `ram_oe`=1, `ram_we`=0.
- `cnt`≠0: decrement and stay.
- `cnt`=0: capture `ram_rdata` into the owner's data register (read only) and go to DONE.

**DONE**
- Assert the owner's done for exactly this cycle.
- `ram_we`=`ram_oe`=0. `ram_addr` and `ram_wdata` keep their latched values.
- Always return to IDLE.

**Data registers**
- `if_data` and `dm_rdata` hold their value until the next read by the same owner overwrites them.
- A DM write does not modify `dm_rdata`.

**Priority**
- DM is the older instruction, so it wins whenever both requests are high in IDLE.
- IF cannot starve: DM issues at most one access per instruction and drops `dm_req` on `dm_done`.

**Reset (`rst`=0)**
- Asynchronously forces IDLE, `cnt`=0, owner=IF.
- All latched fields cleared.
- All outputs 0: `if_data`, `dm_rdata`, `ram_addr`, `ram_wdata`, `ram_we`, `ram_oe`, both done, both stall.
- Reset during ACCESS aborts the access with no done pulse. `ram_we` deasserts immediately; a write in progress is lost.

## Timing
- Access occupancy is WAIT_CYCLES+3 cycles from request sampled in IDLE to the return to IDLE.
- Done pulse position: IDLE edge, then WAIT_CYCLES+1 ACCESS cycles, then the DONE cycle. For WAIT_CYCLES=1, done is high in the 4th cycle counting the request cycle as cycle 1.
- Back-to-back: the earliest next grant is the IDLE cycle immediately after DONE.
- A requester that drops `req` during ACCESS still gets its access completed and its done pulsed. Stall falls with the request.
- Request inputs are sampled only in IDLE. Address and data changes after the grant are ignored.
- Stall is combinational from `req` and done. A requester raising `req` sees stall=1 in the same cycle.
- Both requesters done in the same cycle is impossible; the bench asserts this never occurs.
- `ram_we` is never high outside ACCESS. `ram_we` and `ram_oe` are never high together.

## Test plan
- **IF read, WAIT_CYCLES=1.** Hold `if_req`=1, `if_addr`=0x10; SRAM model returns 0xDEADBEEF at word 4 → `ram_addr`=4 with `ram_oe`=1 for 2 cycles; `if_done` in cycle 4 with `if_data`=0xDEADBEEF; `if_stall`=1 in cycles 1–3.
- **Simultaneous requests.** `if_req`=`dm_req`=1, `dm_we`=1, `dm_addr`=0x20, `dm_wdata`=0x12345678 → DM granted first; word 8 written with `ram_we`=1 for 2 cycles; `dm_done` in cycle 4; IF granted in cycle 5 with `if_done` in cycle 8.
- **Back-to-back IF, WAIT_CYCLES=0.** `if_req` held with addresses 0x0 then 0x4 → `if_done` pulses in cycles 3 and 6, returning words 0 and 1.
- **Request withdrawn mid-access.** Drop `dm_req` during ACCESS of a read → `dm_done` still pulses and `dm_rdata` updates; `dm_stall` is 0 from the drop.
- **Reset mid-write.** Assert `rst`=0 asynchronously in the middle of ACCESS → `ram_we` falls before the next edge; all outputs 0; no done pulse. After release, `if_req` is serviced normally.
- **Misaligned address.** `if_addr`=0x13 → `ram_addr`=4.
